ste_cycle_ctrl: RTL

- Sequences every STEbus slave cycle on the MIO board.
- Synchronises the bus command strobe and decodes the 5-bit address into regions (keyboard, sound, printer, compactflash, rtc).
- Drives chip selects and rd/wr strobes with per-region setup/wait timing, then returns datack.
- Replaces the free-running combinational strobes and gives the on-chip keyboard and sound blocks clean single-cycle write pulses.

---
 rtl/ste_cycle_ctrl_if.sv | 27 ++
 rtl/ste_cycle_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ste_cycle_ctrl_if.sv
// STEbus slave-side command interface for ste_cycle_ctrl.
//   addr   : 5-bit STEbus address
//   cm0    : 0 = write, 1 = read
//   ce     : command strobe, active low, asynchronous to the controller clock
//   datack : acknowledge, active low, driven by the slave
// master modport is the bus side (drives the command), slave modport is the
// cycle controller.
interface ste_cycle_ctrl_if;
  logic [4:0] addr;
  logic       cm0;
  logic       ce;
  logic       datack;

  modport master (
    output addr,
    output cm0,
    output ce,
    input  datack
  );

  modport slave (
    input  addr,
    input  cm0,
    input  ce,
    output datack
  );
endinterface

// File: rtl/ste_cycle_ctrl.sv
// STEbus slave cycle sequencer for the MIO board.
// Synchronises ce, decodes the captured address into a region and runs each
// cycle through SETUP (chip select only), STROBE (rd/wr or internal pulse),
// ACK (datack low until ce returns high) and a one-cycle RELEASE.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : addr, cm0, ce in; datack out (active low)
//   cs_compactflash,
//   cs_printer, cs_rtc  : external chip selects, active low
//   rd, wr              : external strobes, active low
//   kbd_wr, snd_wr      : single-cycle write pulses to on-chip blocks
//   kbd_rd              : keyboard read in progress (data driver enable)
//   kbd_a0              : addr[0] captured at cycle start
// All outputs are registered.
module ste_cycle_ctrl #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned WAIT_CF   = 3,
  parameter int unsigned WAIT_PRN  = 1,
  parameter int unsigned WAIT_RTC  = 2,
  parameter int unsigned WAIT_INT  = 0
) (
  input  logic              clk,
  input  logic              reset,
  ste_cycle_ctrl_if.slave   bus,
  output logic              cs_compactflash,
  output logic              cs_printer,
  output logic              cs_rtc,
  output logic              rd,
  output logic              wr,
  output logic              kbd_wr,
  output logic              snd_wr,
  output logic              kbd_rd,
  output logic              kbd_a0
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_ACK,
    ST_RELEASE
  } state_t;

  typedef enum logic [2:0] {
    RG_KBD,
    RG_SND,
    RG_PRN,
    RG_CF,
    RG_RTC
  } region_t;

  localparam logic [3:0] SETUP_L = 4'(SETUP_CYC);
  localparam logic [3:0] WCF_L   = 4'(WAIT_CF);
  localparam logic [3:0] WPRN_L  = 4'(WAIT_PRN);
  localparam logic [3:0] WRTC_L  = 4'(WAIT_RTC);
  localparam logic [3:0] WINT_L  = 4'(WAIT_INT);

  function automatic region_t decode(input logic [4:0] a);
    region_t r;
    if (a[4])      r = RG_RTC;
    else if (a[3]) r = RG_CF;
    else if (a[2]) r = RG_PRN;
    else if (a[1]) r = RG_SND;
    else           r = RG_KBD;
    return r;
  endfunction

  function automatic logic [3:0] wait_of(input region_t r);
    logic [3:0] w;
    case (r)
      RG_CF:   w = WCF_L;
      RG_PRN:  w = WPRN_L;
      RG_RTC:  w = WRTC_L;
      default: w = WINT_L;
    endcase
    return w;
  endfunction

  function automatic logic is_external(input region_t r);
    return (r == RG_PRN) || (r == RG_CF) || (r == RG_RTC);
  endfunction

  logic       ce_meta;
  logic       ce_s;
  state_t     state;
  region_t    region;
  region_t    region_in;
  logic       cm0_l;
  logic [3:0] cnt;
  logic       datack_q;
  logic       do_release;

  assign bus.datack = datack_q;
  assign region_in  = decode(bus.addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_meta <= 1'b1;
      ce_s    <= 1'b1;
    end else begin
      ce_meta <= bus.ce;
      ce_s    <= ce_meta;
    end
  end

  // ce returning high ends the cycle from SETUP/STROBE (abort) or ACK alike.
  always_comb begin
    do_release = 1'b0;
    if (ce_s && (state == ST_SETUP || state == ST_STROBE || state == ST_ACK))
      do_release = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      region          <= RG_KBD;
      cm0_l           <= 1'b0;
      cnt             <= '0;
      datack_q        <= 1'b1;
      cs_compactflash <= 1'b1;
      cs_printer      <= 1'b1;
      cs_rtc          <= 1'b1;
      rd              <= 1'b1;
      wr              <= 1'b1;
      kbd_wr          <= 1'b0;
      snd_wr          <= 1'b0;
      kbd_rd          <= 1'b0;
      kbd_a0          <= 1'b0;
    end else begin
      kbd_wr <= 1'b0;
      snd_wr <= 1'b0;
      if (do_release) begin
        state           <= ST_RELEASE;
        datack_q        <= 1'b1;
        cs_compactflash <= 1'b1;
        cs_printer      <= 1'b1;
        cs_rtc          <= 1'b1;
        rd              <= 1'b1;
        wr              <= 1'b1;
        kbd_rd          <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!ce_s) begin
              state           <= ST_SETUP;
              region          <= region_in;
              cm0_l           <= bus.cm0;
              kbd_a0          <= bus.addr[0];
              cnt             <= SETUP_L;
              cs_compactflash <= (region_in != RG_CF);
              cs_printer      <= (region_in != RG_PRN);
              cs_rtc          <= (region_in != RG_RTC);
            end
          end
          ST_SETUP: begin
            // Exit when the count is 1 or 0: setup lasts SETUP_CYC cycles,
            // with a floor of one cycle when SETUP_CYC is 0.
            if (cnt < 4'd2) begin
              state <= ST_STROBE;
              cnt   <= wait_of(region);
              if (is_external(region)) begin
                rd <= !cm0_l;
                wr <= cm0_l;
              end else if (region == RG_KBD) begin
                if (cm0_l) kbd_rd <= 1'b1;
                else       kbd_wr <= 1'b1;
              end else if (!cm0_l) begin
                snd_wr <= 1'b1;
              end
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_STROBE: begin
            if (cnt == 4'd0) begin
              state    <= ST_ACK;
              datack_q <= 1'b0;
              // Writes drop the strobe on ACK entry; cs holds the data one cycle.
              if (!cm0_l) wr <= 1'b1;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          ST_ACK: begin
            state <= ST_ACK;
          end
          ST_RELEASE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
